// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle integer ops plus iterative unsigned multiply/divide
// that write HI/LO after WIDTH cycles under a start/busy/done handshake.
module alu_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [3:0]       ALUctr,
  input  logic             start,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OpAddu  = 4'b0000;
  localparam logic [3:0] OpSubu  = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpLui   = 4'b0011;
  localparam logic [3:0] OpOr    = 4'b0100;
  localparam logic [3:0] OpXor   = 4'b0101;
  localparam logic [3:0] OpSlt   = 4'b0110;
  localparam logic [3:0] OpSltu  = 4'b0111;
  localparam logic [3:0] OpMultu = 4'b1000;
  localparam logic [3:0] OpDivu  = 4'b1001;
  localparam logic [3:0] OpMfhi  = 4'b1010;
  localparam logic [3:0] OpMflo  = 4'b1011;

  localparam int unsigned Half = WIDTH / 2;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic                   div_q, div_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic                   launch;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         rem_sh;
  logic [WIDTH-1:0]       rem_diff;
  logic                   rem_ge;
  logic [2*WIDTH-1:0]     div_next;
  logic [2*WIDTH-1:0]     step;

  assign launch = start && (state_q != StRun) &&
                  ((ALUctr == OpMultu) || (ALUctr == OpDivu));

  // work_q holds {accumulator/remainder, multiplier/dividend-quotient}.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    rem_sh   = work_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_sh[WIDTH-1:0] - b_q;
    // A zero divisor always "fits", giving quotient all ones and remainder = dividend.
    div_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), work_q[WIDTH-2:0], rem_ge};
    step     = div_q ? div_next : mul_next;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    b_d     = b_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (launch) begin
          state_d = StRun;
          cnt_d   = '0;
          work_d  = {{WIDTH{1'b0}}, busA};
          b_d     = busB;
          div_d   = (ALUctr == OpDivu);
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d = step;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          hi_d    = step[2*WIDTH-1:WIDTH];
          lo_d    = step[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      b_q     <= b_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    Out = '0;
    unique case (ALUctr)
      OpAddu:  Out = busA + busB;
      OpSubu:  Out = busA - busB;
      OpAnd:   Out = busA & busB;
      OpLui:   Out = {busB[Half-1:0], {Half{1'b0}}};
      OpOr:    Out = busA | busB;
      OpXor:   Out = busA ^ busB;
      OpSlt:   Out = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(busB))};
      OpSltu:  Out = {{(WIDTH-1){1'b0}}, (busA < busB)};
      OpMfhi:  Out = hi_q;
      OpMflo:  Out = lo_q;
      default: Out = '0;
    endcase
  end

  assign zero = (Out == '0);
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md at WIDTH=32 and WIDTH=8; multi-cycle results are checked by a
// scoreboard monitor that pairs each done pulse with the oldest expected entry.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a32, b32, out32, hi32, lo32;
  logic [3:0]  op32;
  logic        st32, zero32, busy32, done32;
  logic [7:0]  a8, b8, out8, hi8, lo8;
  logic [3:0]  op8;
  logic        st8, zero8, busy8, done8;

  alu_md #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .busA(a32), .busB(b32), .ALUctr(op32), .start(st32),
    .Out(out32), .zero(zero32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  alu_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .busA(a8), .busB(b8), .ALUctr(op8), .start(st8),
    .Out(out8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          w8;
    int unsigned due;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] out;
    logic        z;
  } comb_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL done_timeout: got none expected done at cycle %0d", q[0].due);
        void'(q.pop_front());
      end
      if (done32 || done8) begin
        if (q.size() == 0 || q[0].w8 != done8) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done32=%b done8=%b expected none (cycle %0d)",
                   done32, done8, cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("result_hi", e.w8 ? {24'b0, hi8} : hi32, e.hi);
          chk("result_lo", e.w8 ? {24'b0, lo8} : lo32, e.lo);
        end
      end
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input bit w8, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input bit push,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; st8 = 1'b1;
    end else begin
      a32 = a; b32 = b; op32 = op; st32 = 1'b1;
    end
    if (push) begin
      e.w8 = w8; e.due = cyc + 1 + (w8 ? 8 : 32); e.hi = ehi; e.lo = elo;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input bit w8);
    int n = 0;
    int w = w8 ? 8 : 32;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      st32 = 1'b0;
      st8  = 1'b0;
      if (w8 ? busy8 : busy32) n++;
    end
    chk("busy_len", n, w);
    @(negedge clk);
    chk("busy_fall", {31'b0, (w8 ? busy8 : busy32)}, 32'd0);
    chk("done_pulse", {31'b0, (w8 ? done8 : done32)}, 32'd1);
  endtask

  task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    issue(w8, a, b, op, 1'b1, ehi, elo);
    wait_done(w8);
    if (w8) op8 = 4'hA; else op32 = 4'hA;
    #1 chk("mfhi", w8 ? {24'b0, out8} : out32, ehi);
    if (w8) op8 = 4'hB; else op32 = 4'hB;
    #1 chk("mflo", w8 ? {24'b0, out8} : out32, elo);
  endtask

  comb_t vec[10];

  initial begin
    int ndone;
    rst_n = 1'b0;
    a32 = '0; b32 = '0; op32 = 4'hA; st32 = 1'b0;
    a8 = '0; b8 = '0; op8 = 4'h0; st8 = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_hi", hi32, 32'd0);
    chk("rst_lo", lo32, 32'd0);
    chk("rst_mfhi", out32, 32'd0);
    chk("rst_zero", {31'b0, zero32}, 32'd1);
    chk("rst_hi8", {24'b0, hi8}, 32'd0);
    rst_n = 1'b1;

    vec[0] = '{32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0, 1'b1};
    vec[1] = '{32'h3, 32'h5, 4'h1, 32'hFFFF_FFFE, 1'b0};
    vec[2] = '{32'hDEAD_0000, 32'h1234, 4'h3, 32'h1234_0000, 1'b0};
    vec[3] = '{32'hFFFF_FFFF, 32'h1, 4'h6, 32'h1, 1'b0};
    vec[4] = '{32'hFFFF_FFFF, 32'h1, 4'h7, 32'h0, 1'b1};
    vec[5] = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h2, 32'h00F0_000F, 1'b0};
    vec[6] = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h4, 32'hFFF0_0FFF, 1'b0};
    vec[7] = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5, 32'hFF00_0FF0, 1'b0};
    vec[8] = '{32'h5, 32'h5, 4'hC, 32'h0, 1'b1};
    vec[9] = '{32'h5, 32'h5, 4'h8, 32'h0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a32 = vec[i].a; b32 = vec[i].b; op32 = vec[i].op;
      #1;
      chk($sformatf("comb_out[%0d]", i), out32, vec[i].out);
      chk($sformatf("comb_zero[%0d]", i), {31'b0, zero32}, {31'b0, vec[i].z});
    end

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(1'b0, 32'd100, 32'd7, 4'h9, 32'd2, 32'd14);
    run_op(1'b0, 32'd5, 32'd0, 4'h9, 32'd5, 32'hFFFF_FFFF);

    // Stray start and operand changes mid-RUN, then back-to-back start in the done cycle.
    @(negedge clk);
    issue(1'b0, 32'h8000_0000, 32'd6, 4'h8, 1'b1, 32'd3, 32'd0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      st32 = 1'b0;
      if (i == 4) begin
        op32 = 4'hA;
        #1 chk("mfhi_during_run", out32, 32'd5);
      end
      if (i == 5) begin
        a32 = 32'd12; b32 = 32'd4; op32 = 4'h9; st32 = 1'b1;
      end
      if (i == 6) begin
        a32 = 32'd7; b32 = 32'd0;
      end
      if (i == 32) chk("busy_mid", {31'b0, busy32}, 32'd1);
    end
    @(negedge clk);
    chk("done_b2b_first", {31'b0, done32}, 32'd1);
    issue(1'b0, 32'd200, 32'd9, 4'h9, 1'b1, 32'd2, 32'd22);
    wait_done(1'b0);

    // Reset during a multiply: results discarded, no done afterwards.
    @(negedge clk);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      st32 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy32}, 32'd0);
    chk("rst_mid_done", {31'b0, done32}, 32'd0);
    chk("rst_mid_hi", hi32, 32'd0);
    chk("rst_mid_lo", lo32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    chk("no_done_after_rst", ndone, 32'd0);

    run_op(1'b1, 32'hFF, 32'hFF, 4'h8, 32'hFE, 32'h01);
    run_op(1'b1, 32'd100, 32'd7, 4'h9, 32'd2, 32'd14);
    run_op(1'b1, 32'd5, 32'd0, 4'h9, 32'd5, 32'hFF);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
